// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and the forward S-box.
//   aes_block_t / aes_word_t : 128-bit block, 32-bit word
//   AES_NR                   : rounds for AES-128
//   AES_RCON[1:10]           : round constants (MSB byte of the Rcon word)
//   aes_sbox(b)              : forward S-box lookup
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  localparam int AES_NR = 10;

  localparam logic [7:0] AES_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Entry 0 is the leftmost byte of the first row.
  localparam logic [0:255][7:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return AES_SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational SubWord, four parallel S-box lookups.
//   i_word : input word
//   o_word : byte-wise S-box substitution of i_word
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t i_word,
  output aes_word_t o_word
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign o_word[8*g +: 8] = aes_sbox(i_word[8*g +: 8]);
  end

endmodule

// File: rtl/key_expansion.sv
// key_expansion: iterative AES-128 key schedule, one round key per clock.
//   clk, rst    : clock, synchronous active-high reset
//   valid_i     : start request carrying key_i (accepted only when idle)
//   key_i       : cipher key, byte 0 in key_i[127:120]
//   valid_o     : one-cycle pulse, round_key_o holds a complete schedule
//   round_key_o : round keys 0..NR, [0] is the cipher key
//   ready_o     : only when KEY_EXP_READY_EN is defined; high while idle
module key_expansion
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  aes_block_t key_i,
`ifdef KEY_EXP_READY_EN
  output logic       ready_o,
`endif
  output logic       valid_o,
  output aes_block_t round_key_o [NR+1]
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     r_state;
  logic [3:0] r_rnd;
  // Copy of the most recently produced round key; avoids a wide read mux
  // on round_key_o indexed by r_rnd-1.
  aes_block_t r_last;

  aes_word_t  w_sub;
  aes_word_t  w_temp;
  logic [7:0] w_rcon;
  aes_block_t w_next;

  // RotWord on the last word of the previous round key feeds SubWord.
  aes_sub_word u_sub_word (
    .i_word ({r_last[23:0], r_last[31:24]}),
    .o_word (w_sub)
  );

  // r_rnd is outside 1..NR only while idle, where w_next is unused.
  assign w_rcon = (r_rnd >= 4'd1 && r_rnd <= 4'(NR)) ? AES_RCON[r_rnd] : 8'h00;
  assign w_temp = w_sub ^ {w_rcon, 24'h0};

  // Each new word chains off the word just produced in this round.
  assign w_next[127:96] = r_last[127:96] ^ w_temp;
  assign w_next[95:64]  = r_last[95:64]  ^ w_next[127:96];
  assign w_next[63:32]  = r_last[63:32]  ^ w_next[95:64];
  assign w_next[31:0]   = r_last[31:0]   ^ w_next[63:32];

`ifdef KEY_EXP_READY_EN
  assign ready_o = !rst && (r_state == IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rnd   <= 4'd0;
      r_last  <= '0;
      valid_o <= 1'b0;
      for (int i = 0; i <= NR; i++) round_key_o[i] <= '0;
    end else begin
      valid_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            round_key_o[0] <= key_i;
            r_last         <= key_i;
            r_rnd          <= 4'd1;
            r_state        <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 1; i <= NR; i++)
            if (r_rnd == 4'(i)) round_key_o[i] <= w_next;
          r_last <= w_next;
          if (r_rnd == 4'(NR)) begin
            valid_o <= 1'b1;
            r_rnd   <= 4'd0;
            r_state <= IDLE;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         valid_o;
  logic [127:0] round_key_o [11];
`ifdef KEY_EXP_READY_EN
  logic         ready_o;
`endif

  key_expansion dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .key_i       (key_i),
`ifdef KEY_EXP_READY_EN
    .ready_o     (ready_o),
`endif
    .valid_o     (valid_o),
    .round_key_o (round_key_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t [256];
  logic [7:0]   rcon_t [1:10];
  logic [127:0] exp_rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] inv, r;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                  rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      rcon_t[i] = r;
      r = gmul(r, 8'h02);
    end
  endtask

  // FIPS-197 KeyExpansion over the flat 44-word array.
  task automatic compute_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon_t[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  // Caller sits #1 after an edge; the key is accepted at the next edge.
  task automatic accept_key(input logic [127:0] k);
    valid_i = 1'b1;
    key_i   = k;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Edges until valid_o is seen (#1 after the edge); 0 if never within 30.
  task automatic wait_vo(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (valid_o) begin
        cyc = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid_o got=%b want=0", valid_o);
    else n_pass++;
    for (int r = 0; r < 11; r++) begin
      n_chk++;
      if (round_key_o[r] !== 128'h0) $display("FAIL reset_rk[%0d] got=%h want=0", r, round_key_o[r]);
      else n_pass++;
    end
`ifdef KEY_EXP_READY_EN
    n_chk++;
    if (ready_o !== 1'b0) $display("FAIL reset_ready got=%b want=0", ready_o);
    else n_pass++;
`endif
    rst = 1'b0;
    @(posedge clk); #1;
`ifdef KEY_EXP_READY_EN
    n_chk++;
    if (ready_o !== 1'b1) $display("FAIL post_reset_ready got=%b want=1", ready_o);
    else n_pass++;
`endif
  endtask

  task automatic test_fips();
    int cyc;
    logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    accept_key(k);
    wait_vo(cyc);
    n_chk++;
    if (cyc != 10) $display("FAIL fips_latency got=%0d want=10 (edges after accept, sampled +1)", cyc);
    else n_pass++;
    n_chk++;
    if (round_key_o[0] !== k) $display("FAIL fips_rk0 got=%h want=%h", round_key_o[0], k);
    else n_pass++;
    n_chk++;
    if (round_key_o[1] !== 128'ha0fafe1788542cb123a339392a6c7605)
      $display("FAIL fips_rk1 got=%h want=a0fafe1788542cb123a339392a6c7605", round_key_o[1]);
    else n_pass++;
    n_chk++;
    if (round_key_o[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
      $display("FAIL fips_rk10 got=%h want=d014f9a8c9ee2589e13f0cc8b6630ca6", round_key_o[10]);
    else n_pass++;
    compute_ref(k);
    for (int r = 0; r < 11; r++) begin
      n_chk++;
      if (round_key_o[r] !== exp_rk[r]) $display("FAIL fips_model_rk[%0d] got=%h want=%h", r, round_key_o[r], exp_rk[r]);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_chk++;
    if (valid_o !== 1'b0) $display("FAIL fips_pulse_width got=%b want=0", valid_o);
    else n_pass++;
  endtask

  task automatic test_zero_ones();
    int cyc;
    accept_key(128'h0);
    wait_vo(cyc);
    n_chk++;
    if (cyc != 10) $display("FAIL zero_latency got=%0d want=10", cyc);
    else n_pass++;
    n_chk++;
    if (round_key_o[1] !== 128'h62636363626363636263636362636363)
      $display("FAIL zero_rk1 got=%h want=62636363626363636263636362636363", round_key_o[1]);
    else n_pass++;
    n_chk++;
    if (round_key_o[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e)
      $display("FAIL zero_rk10 got=%h want=b4ef5bcb3e92e21123e951cf6f8f188e", round_key_o[10]);
    else n_pass++;
    @(posedge clk); #1;
    accept_key({128{1'b1}});
    wait_vo(cyc);
    n_chk++;
    if (round_key_o[1] !== 128'he8e9e9e917161616e8e9e9e917161616)
      $display("FAIL ones_rk1 got=%h want=e8e9e9e917161616e8e9e9e917161616", round_key_o[1]);
    else n_pass++;
    compute_ref({128{1'b1}});
    n_chk++;
    if (round_key_o[10] !== exp_rk[10]) $display("FAIL ones_rk10 got=%h want=%h", round_key_o[10], exp_rk[10]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int cyc;
    logic [127:0] k;
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      accept_key(k);
      wait_vo(cyc);
      compute_ref(k);
      n_chk++;
      if (cyc != 10) $display("FAIL rand%0d_latency got=%0d want=10", n, cyc);
      else n_pass++;
      for (int r = 0; r < 11; r++) begin
        n_chk++;
        if (round_key_o[r] !== exp_rk[r]) $display("FAIL rand%0d_rk[%0d] got=%h want=%h", n, r, round_key_o[r], exp_rk[r]);
        else n_pass++;
      end
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    logic [127:0] k1 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    accept_key(k1);
    wait_vo(c1);
    compute_ref(k1);
    n_chk++;
    if (round_key_o[10] !== exp_rk[10]) $display("FAIL b2b_first_rk10 got=%h want=%h", round_key_o[10], exp_rk[10]);
    else n_pass++;
    // valid_o is high now: the next key goes in during the pulse cycle.
    accept_key(k2);
    n_chk++;
    if (valid_o !== 1'b0) $display("FAIL b2b_pulse_width got=%b want=0", valid_o);
    else n_pass++;
    wait_vo(c2);
    n_chk++;
    if (c1 != 10 || c2 + 1 != 11) $display("FAIL b2b_spacing got=%0d,%0d want=10,11", c1, c2 + 1);
    else n_pass++;
    compute_ref(k2);
    for (int r = 0; r < 11; r++) begin
      n_chk++;
      if (round_key_o[r] !== exp_rk[r]) $display("FAIL b2b_second_rk[%0d] got=%h want=%h", r, round_key_o[r], exp_rk[r]);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_reject();
    int cyc, extra;
    logic [127:0] ka = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] kb = ~ka;
    accept_key(ka);
    repeat (4) @(posedge clk);
    #1;
    // Round 5 is written at this edge; the request must be ignored.
    accept_key(kb);
    wait_vo(cyc);
    n_chk++;
    if (cyc + 5 != 10) $display("FAIL busy_latency got=%0d want=10", cyc + 5);
    else n_pass++;
    compute_ref(ka);
    for (int r = 0; r < 11; r++) begin
      n_chk++;
      if (round_key_o[r] !== exp_rk[r]) $display("FAIL busy_rk[%0d] got=%h want=%h", r, round_key_o[r], exp_rk[r]);
      else n_pass++;
    end
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid_o) extra++;
    end
    n_chk++;
    if (extra != 0) $display("FAIL busy_extra_pulses got=%0d want=0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc, pulses;
    logic [127:0] kc = {$urandom, $urandom, $urandom, $urandom};
    accept_key({$urandom, $urandom, $urandom, $urandom});
    repeat (5) @(posedge clk);
    #1;
    // Reset at round 6, with a competing start request that must be dropped.
    rst = 1'b1;
    valid_i = 1'b1;
    key_i = kc;
    @(posedge clk); #1;
    rst = 1'b0;
    valid_i = 1'b0;
    n_chk++;
    if (valid_o !== 1'b0) $display("FAIL rstmid_valid_o got=%b want=0", valid_o);
    else n_pass++;
    for (int r = 0; r < 11; r++) begin
      n_chk++;
      if (round_key_o[r] !== 128'h0) $display("FAIL rstmid_rk[%0d] got=%h want=0", r, round_key_o[r]);
      else n_pass++;
    end
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid_o) pulses++;
    end
    n_chk++;
    if (pulses != 0) $display("FAIL rstmid_pulses got=%0d want=0", pulses);
    else n_pass++;
    accept_key(kc);
    wait_vo(cyc);
    n_chk++;
    if (cyc != 10) $display("FAIL rstmid_latency got=%0d want=10", cyc);
    else n_pass++;
    compute_ref(kc);
    for (int r = 0; r < 11; r++) begin
      n_chk++;
      if (round_key_o[r] !== exp_rk[r]) $display("FAIL rstmid_rk_after[%0d] got=%h want=%h", r, round_key_o[r], exp_rk[r]);
      else n_pass++;
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips();
    test_zero_ones();
    test_random();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
